// File: rtl/tpu_host_seq.sv
// Bus initiator for the tpuv1 matmul unit: loads A and B rows, strobes start,
// waits a fixed compute time, then streams the C half-rows out over valid/ready.
module tpu_host_seq #(
  parameter int DIM      = 8,
  parameter int BITS_C   = 16,
  parameter int ADDRW    = 16,
  parameter int DATAW    = 64,
  parameter int WAIT_CYC = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             ab_valid,
  output logic             ab_ready,
  input  logic [DATAW-1:0] ab_data,
  output logic             c_valid,
  input  logic             c_ready,
  output logic [DATAW-1:0] c_data,
  output logic [$clog2(DIM)-1:0] c_row,
  output logic             c_half,
  output logic             busy,
  output logic             done,
  output logic             tpu_r_w,
  output logic [ADDRW-1:0] tpu_addr,
  output logic [DATAW-1:0] tpu_wdata,
  input  logic [DATAW-1:0] tpu_rdata
);

  localparam int RW     = $clog2(DIM);
  localparam int WW     = $clog2(WAIT_CYC + 1);
  localparam int HALVES = (DIM * BITS_C) / DATAW;
  localparam int NBEATS = DIM * HALVES;

  localparam logic [RW-1:0] ROW_LAST  = RW'(DIM - 1);
  localparam logic [RW:0]   IDX_LAST  = (RW + 1)'(NBEATS - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_CYC - 1);

  localparam logic [ADDRW-1:0] A_BASE = ADDRW'(12'h100);
  localparam logic [ADDRW-1:0] B_BASE = ADDRW'(12'h200);
  localparam logic [ADDRW-1:0] C_BASE = ADDRW'(12'h300);
  localparam logic [ADDRW-1:0] S_ADDR = ADDRW'(12'h400);

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, START, WAIT, READ_C} state_t;

  state_t          state;
  logic [RW-1:0]   row_cnt;
  logic [WW-1:0]   wait_cnt;
  logic [RW:0]     rd_idx;
  logic            rd_all;
  logic            rd_bus;
  logic            ab_fire;
  logic            c_fire;
  logic            issue;
  logic            last_beat;

  assign cmd_ready = (state == IDLE);
  assign ab_ready  = (state == LOAD_A) || (state == LOAD_B);
  assign busy      = (state != IDLE);
  assign ab_fire   = ab_valid && ab_ready;
  assign c_fire    = c_valid && c_ready;
  assign last_beat = c_fire && (c_row == ROW_LAST) && c_half;

  // A read may go out only if the output register will be empty when it lands.
  assign issue = (state == READ_C) && !rd_all && !rd_bus && (!c_valid || c_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      row_cnt   <= '0;
      wait_cnt  <= '0;
      rd_idx    <= '0;
      rd_all    <= 1'b0;
      rd_bus    <= 1'b0;
      c_valid   <= 1'b0;
      done      <= 1'b0;
      tpu_r_w   <= 1'b0;
      tpu_addr  <= '0;
      tpu_wdata <= '0;
    end else begin
      // The TPU decodes every cycle, so the bus falls back to idle unless driven.
      tpu_r_w   <= 1'b0;
      tpu_addr  <= '0;
      tpu_wdata <= '0;
      done      <= 1'b0;
      rd_bus    <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            state    <= LOAD_A;
            row_cnt  <= '0;
            wait_cnt <= '0;
            rd_idx   <= '0;
            rd_all   <= 1'b0;
          end
        end
        LOAD_A, LOAD_B: begin
          if (ab_fire) begin
            tpu_r_w   <= 1'b1;
            tpu_addr  <= ((state == LOAD_A) ? A_BASE : B_BASE) | (ADDRW'(row_cnt) << 3);
            tpu_wdata <= ab_data;
            if (row_cnt == ROW_LAST) begin
              row_cnt <= '0;
              state   <= (state == LOAD_A) ? LOAD_B : START;
            end else begin
              row_cnt <= row_cnt + 1'b1;
            end
          end
        end
        START: begin
          tpu_r_w  <= 1'b1;
          tpu_addr <= S_ADDR;
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (wait_cnt == WAIT_LAST) state <= READ_C;
        end
        READ_C: begin
          if (rd_bus)      c_valid <= 1'b1;
          else if (c_fire) c_valid <= 1'b0;
          if (issue) begin
            tpu_addr <= C_BASE | (ADDRW'(rd_idx) << 3);
            rd_bus   <= 1'b1;
            rd_idx   <= rd_idx + 1'b1;
            if (rd_idx == IDX_LAST) rd_all <= 1'b1;
          end
          if (last_beat) done  <= 1'b1;
          if (done)      state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Capture stage: row/half come straight from the read address on the bus.
  always_ff @(posedge clk) begin
    if (rd_bus) begin
      c_data <= tpu_rdata;
      c_row  <= tpu_addr[RW+3:4];
      c_half <= tpu_addr[3];
    end
  end

endmodule
